button_step_ctrl: RTL and testbench
===================================

# button_step_ctrl

Input conditioner placed directly upstream of the 8-bit up/down counter. Takes two raw, asynchronous push-buttons, synchronises and debounces them, and drives the counter's `enable` and `direction` inputs. Each qualified press produces exactly one single-cycle step pulse. Optional auto-repeat produces further pulses while a button is held.

## Interface
- `DEBOUNCE_CYCLES`, default 20: consecutive stable cycles required before a debounced level changes; must be ≥ 2.
- `HOLD_CYCLES`, default 50: cycles a press must be held before auto-repeat starts.
- `REPEAT_CYCLES`, default 10: period of auto-repeat pulses.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `btn_up`  in  1  raw up button, asynchronous, active-high.
- `btn_down`  in  1  raw down button, asynchronous, active-high.
- `enable`  out  1  registered step pulse to counter `enable`; high for exactly one cycle per step.
- `direction`  out  1  registered; 1 = up, 0 = down; wire to counter `direction`.

## Operation
- Synchroniser: each button passes through two flops (`s1`, `s2`), both cleared by `rst`.
- Debouncer, per button:
  - Debounced level `deb` (reset 0) and a mismatch counter of width `$clog2(DEBOUNCE_CYCLES)`.
  - While `s2 == deb`, the counter clears to 0.
  - While `s2 != deb`, the counter increments.
  - When the counter equals `DEBOUNCE_CYCLES-1` and mismatch persists, `deb` takes `s2` and the counter clears.
  - Any single-cycle return to `deb` restarts the count.
- FSM states:
  - IDLE
    - `deb_up & !deb_down` → pulse, direction=1, goto HOLD.
    - `deb_down & !deb_up` → pulse, direction=0, goto HOLD.
    - Both rise in the same cycle → LOCK, no pulse.
  - HOLD
    - Active button released (`deb` 0) → IDLE.
    - Other button's `deb` rises → LOCK, no pulse.
    - Hold counter reaches `HOLD_CYCLES` (macro only) → pulse, goto REPEAT.
  - REPEAT (macro only)
    - Pulse every `REPEAT_CYCLES` cycles while held.
    - Release → IDLE; other button → LOCK.
  - LOCK: no pulses; return to IDLE only when both `deb` are 0.
- `direction` updates only in the same cycle as a pulse is issued. It holds its last value otherwise, including in LOCK and IDLE.
- Hold/repeat counter: wide enough for `max(HOLD_CYCLES, REPEAT_CYCLES)`; cleared on every state entry; saturates at its terminal value.
- Reset mid-operation clears all state. A button held through reset release is treated as a new press and yields one pulse after the full debounce latency.

## Timing
- Reset values: `enable`=0, `direction`=1, FSM=IDLE, all synchroniser flops, `deb` and counters 0.
- Press latency: raw input first sampled high at edge 0 → `s2` high after edge 1 → `deb` high after edge 1+`DEBOUNCE_CYCLES` → `enable` high after edge 2+`DEBOUNCE_CYCLES`, low after the following edge.
- Release latency is the same; release issues no pulse.
- Auto-repeat timing:
  - First repeat pulse is `HOLD_CYCLES` cycles after the initial pulse.
  - Subsequent pulses are spaced `REPEAT_CYCLES` cycles apart (rising edge to rising edge).
- `enable` is never high on two consecutive cycles, provided `REPEAT_CYCLES` ≥ 2.

## Configuration
- `BUTTON_AUTO_REPEAT_EN` defined:
  - REPEAT state and hold/repeat counter are compiled in.
  - A held button steps repeatedly as described above.
- `BUTTON_AUTO_REPEAT_EN` undefined:
  - No REPEAT state and no hold/repeat counter.
  - HOLD waits only for release or the other button.
  - Exactly one pulse per press regardless of hold duration.
  - `HOLD_CYCLES` and `REPEAT_CYCLES` are unused.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=16, `REPEAT_CYCLES`=8.
- `rst` high 2 cycles, buttons low → `enable`=0, `direction`=1 throughout; no pulses for 50 cycles.
- `btn_down` high from edge 0 for 10 cycles, macro off → single `enable` pulse after edge 6, `direction`=0 from that edge; nothing on release.
- `btn_up` toggling every 2 cycles for 20 cycles, then low → no pulse, `deb_up` never rises.
- `btn_up` held 60 cycles, macro on → pulses after edges 6, 22, 30, 38, 46, 54, 62 (7 pulses), `direction`=1; no further pulses after release.
- `btn_up` and `btn_down` raised on the same edge, then `btn_down` released → no pulse while `btn_up` remains held (LOCK); a new press after both are released yields one pulse.
- `btn_up` held, `rst` pulsed 1 cycle at cycle 20 with button still held → `enable`=0 and `direction`=1 after reset; one new pulse 6 edges after reset deasserts.

Source files
------------

// File: rtl/button_step_ctrl.sv
// button_step_ctrl: synchronises and debounces two raw push-buttons into one-cycle counter step pulses.
// Define BUTTON_AUTO_REPEAT_EN to compile in hold-to-repeat stepping (REPEAT state + hold/repeat counter).
module button_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int HOLD_CYCLES     = 50,
  parameter int REPEAT_CYCLES   = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_up,
  input  logic btn_down,
  output logic enable,
  output logic direction
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("button_step_ctrl: invalid cycle-count parameters");
  end

  // Index 0 is the up button, index 1 the down button.
  logic [1:0] btn_raw;
  logic [1:0] deb;

  assign btn_raw = {btn_down, btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic            s1_reg;
      logic            s2_reg;
      logic            deb_reg;
      logic [DB_W-1:0] cnt_reg;

      // Any sample agreeing with the debounced level restarts the mismatch count.
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_reg  <= 1'b0;
          s2_reg  <= 1'b0;
          deb_reg <= 1'b0;
          cnt_reg <= '0;
        end else begin
          s1_reg <= btn_raw[gi];
          s2_reg <= s1_reg;
          if (s2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DB_LAST) begin
            deb_reg <= s2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign deb[gi] = deb_reg;
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCK} state_t;

  state_t state_reg, state_next;
  logic   enable_reg, direction_reg;
  logic   pulse, dir_next;
  logic   deb_up, deb_down, active_held, other_held;

  assign deb_up   = deb[0];
  assign deb_down = deb[1];
  // While holding, direction_reg identifies which button issued the last step.
  assign active_held = direction_reg ? deb_up   : deb_down;
  assign other_held  = direction_reg ? deb_down : deb_up;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HR_W   = $clog2(HR_MAX + 1);
  localparam logic [HR_W-1:0] HOLD_LAST   = HR_W'(HOLD_CYCLES - 1);
  localparam logic [HR_W-1:0] REPEAT_LAST = HR_W'(REPEAT_CYCLES - 1);

  logic [HR_W-1:0] hr_cnt_reg, hr_cnt_next;
  logic            hr_done;

  assign hr_done = (state_reg == HOLD) ? (hr_cnt_reg == HOLD_LAST) : (hr_cnt_reg == REPEAT_LAST);

  // Restart the period on every state entry and after every repeat pulse; saturate otherwise.
  always_comb begin
    hr_cnt_next = hr_cnt_reg;
    if (state_next != state_reg || pulse) begin
      hr_cnt_next = '0;
    end else if (!hr_done) begin
      hr_cnt_next = hr_cnt_reg + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      enable_reg    <= 1'b0;
      direction_reg <= 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
      hr_cnt_reg    <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      enable_reg    <= pulse;
      direction_reg <= dir_next;
`ifdef BUTTON_AUTO_REPEAT_EN
      hr_cnt_reg    <= hr_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (deb_up && deb_down)      state_next = LOCK;
        else if (deb_up || deb_down) state_next = HOLD;
      end
      HOLD: begin
        if (!active_held)     state_next = IDLE;
        else if (other_held)  state_next = LOCK;
`ifdef BUTTON_AUTO_REPEAT_EN
        else if (hr_done)     state_next = REPEAT;
`endif
      end
`ifdef BUTTON_AUTO_REPEAT_EN
      REPEAT: begin
        if (!active_held)     state_next = IDLE;
        else if (other_held)  state_next = LOCK;
      end
`endif
      LOCK: begin
        if (!deb_up && !deb_down) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pulse    = 1'b0;
    dir_next = direction_reg;
    case (state_reg)
      IDLE: begin
        if (deb_up ^ deb_down) begin
          pulse    = 1'b1;
          dir_next = deb_up;
        end
      end
`ifdef BUTTON_AUTO_REPEAT_EN
      HOLD, REPEAT: begin
        if (active_held && !other_held && hr_done) pulse = 1'b1;
      end
`endif
      default: pulse = 1'b0;
    endcase
  end

  assign enable    = enable_reg;
  assign direction = direction_reg;

endmodule

// File: tb/tb_button_step_ctrl.sv
// Bench for button_step_ctrl: directed scenarios plus random button activity, every cycle checked
// against a window-based debounce / pulse-schedule reference model.
module tb_button_step_ctrl;

  localparam int D = 4;
  localparam int H = 16;
  localparam int R = 8;
`ifdef BUTTON_AUTO_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic enable, direction;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;
  int pulse_cnt = 0;

  // Reference model state: raw_h[b][i] = raw level sampled i+1 edges ago.
  bit m_en, m_dir;
  int m_mode;  // 0 idle, 1 holding, 2 locked
  int m_age;   // edges since the initial pulse of the current hold
  bit m_deb[2];
  bit raw_h[2][D+2];

  button_step_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .enable(enable),
    .direction(direction)
  );

  always #5 clk = ~clk;

  function automatic void model_edge();
    bit du, dd, act, oth, all_diff;
    if (rst) begin
      m_en = 1'b0; m_dir = 1'b1; m_mode = 0; m_age = 0;
      for (int b = 0; b < 2; b++) begin
        m_deb[b] = 1'b0;
        for (int i = 0; i < D + 2; i++) raw_h[b][i] = 1'b0;
      end
      return;
    end
    du = m_deb[0];
    dd = m_deb[1];
    m_en = 1'b0;
    case (m_mode)
      0: begin
        if (du && dd) m_mode = 2;
        else if (du || dd) begin
          m_en = 1'b1; m_dir = du; m_mode = 1; m_age = 0;
        end
      end
      1: begin
        m_age++;
        act = m_dir ? du : dd;
        oth = m_dir ? dd : du;
        if (!act) m_mode = 0;
        else if (oth) m_mode = 2;
        else if (REPEAT_ON && m_age >= H && ((m_age - H) % R) == 0) m_en = 1'b1;
      end
      default: if (!du && !dd) m_mode = 0;
    endcase
    // Debounced level flips once the last D synchronised samples all disagree with it.
    for (int b = 0; b < 2; b++) begin
      all_diff = 1'b1;
      for (int i = 1; i <= D; i++) if (raw_h[b][i] == m_deb[b]) all_diff = 1'b0;
      if (all_diff) m_deb[b] = ~m_deb[b];
      for (int i = D + 1; i >= 1; i--) raw_h[b][i] = raw_h[b][i-1];
      raw_h[b][0] = (b == 0) ? btn_up : btn_down;
    end
  endfunction

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    cycle++;
    tests_run++;
    assert (enable === m_en) else begin
      tests_failed++;
      $error("FAIL %s enable @cycle %0d: observed %b expected %b", tag, cycle, enable, m_en);
    end
    tests_run++;
    assert (direction === m_dir) else begin
      tests_failed++;
      $error("FAIL %s direction @cycle %0d: observed %b expected %b", tag, cycle, direction, m_dir);
    end
    if (enable === 1'b1) pulse_cnt++;
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic expect_pulses(input string tag, input int exp_cnt);
    tests_run++;
    assert (pulse_cnt === exp_cnt) else begin
      tests_failed++;
      $error("FAIL %s pulse_count: observed %0d expected %0d", tag, pulse_cnt, exp_cnt);
    end
    $display("[TB] %s: %0d pulse(s) at cycle %0d", tag, pulse_cnt, cycle);
    pulse_cnt = 0;
  endtask

  initial begin
    int kind;
    // Reset and quiet idle period
    rst = 1'b1;
    run(2, "reset");
    rst = 1'b0;
    run(50, "idle");
    expect_pulses("idle", 0);

    // Single down press, released after 10 cycles
    btn_down = 1'b1;
    run(10, "down_press");
    btn_down = 1'b0;
    run(20, "down_release");
    expect_pulses("down_press", 1);

    // Bouncing up button never settles
    for (int k = 0; k < 5; k++) begin
      btn_up = 1'b1; run(2, "bounce");
      btn_up = 1'b0; run(2, "bounce");
    end
    run(20, "bounce_quiet");
    expect_pulses("bounce", 0);

    // Long up hold: auto-repeat when enabled, a single step otherwise
    btn_up = 1'b1;
    run(60, "long_hold");
    btn_up = 1'b0;
    run(30, "long_release");
    expect_pulses("long_hold", REPEAT_ON ? 7 : 1);

    // Simultaneous press locks out until both are released
    btn_up = 1'b1; btn_down = 1'b1;
    run(20, "both_press");
    btn_down = 1'b0;
    run(20, "lock_up_held");
    btn_up = 1'b0;
    run(20, "lock_release");
    expect_pulses("lock", 0);
    btn_up = 1'b1;
    run(12, "after_lock");
    btn_up = 1'b0;
    run(20, "after_lock_release");
    expect_pulses("after_lock", 1);

    // Reset while held: a fresh press after reset release
    btn_up = 1'b1;
    run(20, "pre_reset_hold");
    expect_pulses("pre_reset_hold", 1);
    rst = 1'b1;
    step("mid_reset");
    rst = 1'b0;
    run(15, "post_reset_hold");
    btn_up = 1'b0;
    run(25, "post_reset_release");
    expect_pulses("post_reset", 1);

    // Random activity: holds, bounces and occasional resets
    for (int seg = 0; seg < 60; seg++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        rst = 1'b1;
        run(int'($urandom_range(1, 2)), "rnd_reset");
        rst = 1'b0;
      end else if (kind <= 2) begin
        for (int n = int'($urandom_range(2, 12)); n > 0; n--) begin
          btn_up   = 1'($urandom_range(0, 1));
          btn_down = 1'($urandom_range(0, 1));
          step("rnd_bounce");
        end
      end else begin
        {btn_down, btn_up} = 2'($urandom_range(0, 3));
        run(int'($urandom_range(1, 45)), "rnd_hold");
      end
      $display("[TB] random segment %0d kind %0d done at cycle %0d", seg, kind, cycle);
    end
    btn_up = 1'b0; btn_down = 1'b0;
    run(20, "final_quiet");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
